// File: rtl/scan_chain_arbiter_if.sv
// Requester-side handshake bundle for the scan-chain arbiter: two request ports
// carrying a scan word and a bit length, each with its own completion ack.
interface scan_chain_arbiter_if #(
    parameter int unsigned SCAN_W = 128,
    parameter int unsigned LEN_W  = 8
);
    logic              req0;
    logic [SCAN_W-1:0] data0;
    logic [LEN_W-1:0]  len0;
    logic              ack0;

    logic              req1;
    logic [SCAN_W-1:0] data1;
    logic [LEN_W-1:0]  len1;
    logic              ack1;

    modport master (
        output req0, data0, len0, req1, data1, len1,
        input  ack0, ack1
    );

    modport slave (
        input  req0, data0, len0, req1, data1, len1,
        output ack0, ack1
    );
endinterface

// File: rtl/scan_chain_arbiter.sv
// Round-robin owner of the tag chip scan-chain pins: serialises the granted word
// MSB-first with non-overlapping two-phase clocks, pulses load_chip, then acks.
module scan_chain_arbiter #(
    parameter int unsigned SCAN_W       = 128,
    parameter int unsigned LEN_W        = 8,
    parameter int unsigned PHASE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    scan_chain_arbiter_if.slave  bus,
    output logic [1:0]           o_grant,
    output logic                 o_busy,
    output logic [LEN_W-1:0]     o_bit_cnt,
    output logic                 o_scan_id,
    output logic                 o_scan_phi,
    output logic                 o_scan_phi_bar,
    output logic                 o_scan_data_in,
    output logic                 o_scan_load_chip
);

    localparam int unsigned      CNT_W    = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(SCAN_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic [LEN_W-1:0]  r_len;
    logic [SCAN_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_phase;
    logic [1:0]        r_grant;
    logic              r_busy;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic              r_scan_id;
    logic              r_phi;
    logic              r_phi_bar;
    logic              r_data_in;
    logic              r_load;
    logic              r_ack0;
    logic              r_ack1;

    logic              w_any_req;
    logic              w_win;
    logic [LEN_W-1:0]  w_req_len;
    logic [LEN_W-1:0]  w_len_c;
    logic [SCAN_W-1:0] w_req_data;
    logic [SCAN_W-1:0] w_aligned;
    logic [LEN_W-1:0]  w_bit_nxt;
    logic              w_cnt_last;

    // Arbitration: a lone request wins; on a tie the port not served last wins.
    assign w_any_req  = bus.req0 | bus.req1;
    assign w_win      = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_req_len  = w_win ? bus.len1 : bus.len0;
    assign w_req_data = w_win ? bus.data1 : bus.data0;
    assign w_len_c    = (w_req_len > LEN_MAX) ? LEN_MAX : w_req_len;
    // Left-justify so data[len-1] sits at the MSB and shifting left walks down to data[0].
    assign w_aligned  = w_req_data << (LEN_MAX - w_len_c);
    assign w_bit_nxt  = r_bit_cnt + LEN_W'(1);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_len     <= '0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_phase   <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_scan_id <= 1'b0;
            r_phi     <= 1'b0;
            r_phi_bar <= 1'b0;
            r_data_in <= 1'b0;
            r_load    <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_win;
                        r_grant   <= w_win ? 2'b10 : 2'b01;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_len     <= w_len_c;
                        r_shreg   <= w_aligned;
                        r_cnt     <= '0;
                        r_phase   <= '0;
                        if (w_len_c == '0) begin
                            r_state <= ST_LOAD;
                            r_load  <= 1'b1;
                        end else begin
                            r_state   <= ST_SHIFT;
                            r_scan_id <= 1'b1;
                            r_data_in <= w_aligned[SCAN_W-1];
                        end
                    end
                end

                ST_SHIFT: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd0: r_phi     <= 1'b1;
                            2'd1: r_phi     <= 1'b0;
                            2'd2: r_phi_bar <= 1'b1;
                            default: begin
                                // End of a bit: count it, then either load or present the next bit.
                                r_phi_bar <= 1'b0;
                                r_bit_cnt <= w_bit_nxt;
                                r_shreg   <= r_shreg << 1;
                                if (w_bit_nxt == r_len) begin
                                    r_state   <= ST_LOAD;
                                    r_scan_id <= 1'b0;
                                    r_data_in <= 1'b0;
                                    r_load    <= 1'b1;
                                end else begin
                                    r_data_in <= r_shreg[SCAN_W-2];
                                end
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_LOAD: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_load  <= 1'b0;
                        r_state <= ST_ACK;
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack0         = r_ack0;
    assign bus.ack1         = r_ack1;
    assign o_grant          = r_grant;
    assign o_busy           = r_busy;
    assign o_bit_cnt        = r_bit_cnt;
    assign o_scan_id        = r_scan_id;
    assign o_scan_phi       = r_phi;
    assign o_scan_phi_bar   = r_phi_bar;
    assign o_scan_data_in   = r_data_in;
    assign o_scan_load_chip = r_load;

endmodule

// File: tb/tb_scan_chain_arbiter.sv
// Bench for scan_chain_arbiter: directed scenarios plus a random run, with a monitor
// that rebuilds each serial stream and checks it against a queue of expected words.
module tb_scan_chain_arbiter;

    localparam int unsigned SCAN_W = 128;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned P      = 2;
    localparam int          BUDGET = 1400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_chain_arbiter_if #(.SCAN_W(SCAN_W), .LEN_W(LEN_W)) bus ();

    logic [1:0]       grant;
    logic             busy;
    logic [LEN_W-1:0] bit_cnt;
    logic             scan_id, phi, phi_bar, data_in, load_chip;

    scan_chain_arbiter #(.SCAN_W(SCAN_W), .LEN_W(LEN_W), .PHASE_CYCLES(P)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .o_grant          (grant),
        .o_busy           (busy),
        .o_bit_cnt        (bit_cnt),
        .o_scan_id        (scan_id),
        .o_scan_phi       (phi),
        .o_scan_phi_bar   (phi_bar),
        .o_scan_data_in   (data_in),
        .o_scan_load_chip (load_chip)
    );

    typedef struct {
        logic              port;
        logic [SCAN_W-1:0] bits;
        int unsigned       len;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   tb_last     = 1'b1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic port, input logic [SCAN_W-1:0] d, input int unsigned len);
        exp_t e;
        logic [SCAN_W-1:0] mask;
        int unsigned l;
        l    = (len > SCAN_W) ? SCAN_W : len;
        mask = '1;
        if (l == 0) mask = '0;
        else        mask = mask >> (SCAN_W - l);
        e.port = port;
        e.bits = d & mask;
        e.len  = l;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        tb_last = 1'b1;
        sb_q.delete();
    endtask

    task automatic wait_grant(input logic [1:0] g, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < BUDGET) begin
            tick();
            n++;
            if (grant === g) ok = 1'b1;
        end
    endtask

    task automatic wait_ack(input logic port, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < BUDGET) begin
            tick();
            n++;
            if ((port ? bus.ack1 : bus.ack0) === 1'b1) ok = 1'b1;
        end
    endtask

    // Monitor: protocol invariants every cycle, stream reconstruction checked at each ack.
    initial begin
        logic [SCAN_W-1:0] m_bits;
        int   m_phi_n, m_pb_n;
        bit   m_phi_q, m_pb_q, m_busy_q;
        logic port;
        exp_t e;
        m_bits = '0; m_phi_n = 0; m_pb_n = 0; m_phi_q = 0; m_pb_q = 0; m_busy_q = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                m_bits = '0; m_phi_n = 0; m_pb_n = 0; m_phi_q = 0; m_pb_q = 0; m_busy_q = 0;
            end else begin
                vectors++;
                if ((phi & phi_bar) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL phi_overlap: phi=%b phi_bar=%b required not both 1", phi, phi_bar);
                end
                vectors++;
                if (!$onehot0(grant) || $isunknown(grant)) begin
                    miscompares++;
                    $display("FAIL grant_onehot: grant=%b required one-hot or 00", grant);
                end
                if (busy === 1'b1 && !m_busy_q) begin
                    m_bits = '0; m_phi_n = 0; m_pb_n = 0;
                end
                if (phi === 1'b1 && !m_phi_q) begin
                    m_bits = {m_bits[SCAN_W-2:0], data_in};
                    m_phi_n++;
                end
                if (phi_bar === 1'b1 && !m_pb_q) m_pb_n++;
                if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                    port = bus.ack1;
                    vectors++;
                    if (grant !== (port ? 2'b10 : 2'b01) || (bus.ack0 & bus.ack1) === 1'b1) begin
                        miscompares++;
                        $display("FAIL ack_grant: ack0=%b ack1=%b grant=%b required ack of the granted port only",
                                 bus.ack0, bus.ack1, grant);
                    end
                    vectors++;
                    if (sb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_empty: ack on port %0d with no expected transaction", port);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.port !== port || m_phi_n != int'(e.len) || m_pb_n != int'(e.len) ||
                            m_bits !== e.bits || bit_cnt !== LEN_W'(e.len)) begin
                            miscompares++;
                            $display("FAIL stream: port %0d phi %0d phibar %0d bit_cnt %0d bits %h; required port %0d len %0d bits %h",
                                     port, m_phi_n, m_pb_n, bit_cnt, m_bits, e.port, e.len, e.bits);
                        end
                    end
                end
                m_phi_q  = (phi === 1'b1);
                m_pb_q   = (phi_bar === 1'b1);
                m_busy_q = (busy === 1'b1);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({grant, busy, bit_cnt, scan_id, phi, phi_bar, data_in, load_chip, bus.ack0, bus.ack1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: grant=%b busy=%b bit_cnt=%0d pins=%b%b%b%b%b ack=%b%b required all 0",
                     grant, busy, bit_cnt, scan_id, phi, phi_bar, data_in, load_chip, bus.ack0, bus.ack1);
        end
        reset   = 1'b0;
        tb_last = 1'b1;
        tick();
        vectors++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: grant=%b busy=%b required 00/0", grant, busy);
        end
    endtask

    task automatic test_basic();
        logic [SCAN_W-1:0] d;
        logic [2:0] pat;
        logic exp_phi, exp_pb, exp_load, exp_ack;
        int b;
        d        = {$urandom, $urandom, $urandom, $urandom};
        d[2:0]   = 3'b101;
        pat      = 3'b101;
        bus.data0 = d;
        bus.len0  = 8'd3;
        bus.req0  = 1'b1;
        push_exp(1'b0, d, 3);
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (k == 2) begin
                bus.data0 = ~d;
                bus.len0  = 8'd7;
            end
            if (k == 1) begin
                vectors++;
                if (grant !== 2'b01 || busy !== 1'b1 || scan_id !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_grant: grant=%b busy=%b scan_id=%b required 01/1/1", grant, busy, scan_id);
                end
            end
            if (k <= 24 && ((k - 1) % 8) == 0) begin
                b = (k - 1) / 8;
                vectors++;
                if (data_in !== pat[2-b] || bit_cnt !== LEN_W'(b)) begin
                    miscompares++;
                    $display("FAIL basic_bit%0d: data_in=%b bit_cnt=%0d required %b/%0d", b, data_in, bit_cnt, pat[2-b], b);
                end
            end
            exp_phi  = (k <= 24) && (((k - 1) % 8) inside {2, 3});
            exp_pb   = (k <= 24) && (((k - 1) % 8) inside {6, 7});
            exp_load = (k == 25 || k == 26);
            exp_ack  = (k == 27);
            vectors++;
            if (phi !== exp_phi || phi_bar !== exp_pb || load_chip !== exp_load || bus.ack0 !== exp_ack) begin
                miscompares++;
                $display("FAIL basic_c%0d: phi=%b phi_bar=%b load=%b ack0=%b required %b/%b/%b/%b",
                         k, phi, phi_bar, load_chip, bus.ack0, exp_phi, exp_pb, exp_load, exp_ack);
            end
            if (k == 27) bus.req0 = 1'b0;
            if (k == 28) begin
                vectors++;
                if (grant !== 2'b00 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_idle: grant=%b busy=%b required 00/0", grant, busy);
                end
            end
        end
        tb_last = 1'b0;
    endtask

    task automatic test_tie();
        bit ok;
        int n;
        do_reset();
        bus.data0 = {4{$urandom}}; bus.len0 = 8'd4;
        bus.data1 = {4{$urandom}}; bus.len1 = 8'd2;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        push_exp(1'b0, bus.data0, 4);
        push_exp(1'b1, bus.data1, 2);
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL tie_first: grant=%b required 01", grant);
        end
        wait_ack(1'b0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL tie_ack0: no ack0 within %0d cycles", BUDGET); end
        bus.req0 = 1'b0;
        wait_grant(2'b10, ok, n);
        vectors++;
        if (!ok || n != 2) begin
            miscompares++;
            $display("FAIL tie_gap: grant 10 after %0d cycles (found=%0d) required 2", n, ok);
        end
        wait_ack(1'b1, ok);
        bus.req1 = 1'b0;
        // Port 1 served last, so the next tie goes to port 0.
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        push_exp(1'b0, bus.data0, 4);
        push_exp(1'b1, bus.data1, 2);
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL tie_after_p1: grant=%b required 01", grant);
        end
        wait_ack(1'b0, ok); bus.req0 = 1'b0;
        wait_ack(1'b1, ok); bus.req1 = 1'b0;
        tick();
        // Port 0 alone, then a tie must go to port 1.
        bus.req0 = 1'b1;
        push_exp(1'b0, bus.data0, 4);
        wait_ack(1'b0, ok); bus.req0 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        push_exp(1'b1, bus.data1, 2);
        push_exp(1'b0, bus.data0, 4);
        tick();
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("FAIL tie_after_p0: grant=%b required 10", grant);
        end
        wait_ack(1'b1, ok); bus.req1 = 1'b0;
        wait_ack(1'b0, ok); bus.req0 = 1'b0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL tie_final_ack: no ack0 within %0d cycles", BUDGET); end
        tb_last = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        logic exp_load, exp_ack;
        bus.data1 = {4{$urandom}};
        bus.len1  = 8'd0;
        bus.req1  = 1'b1;
        push_exp(1'b1, bus.data1, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_load = (k == 1 || k == 2);
            exp_ack  = (k == 3);
            vectors++;
            if (phi !== 1'b0 || phi_bar !== 1'b0 || scan_id !== 1'b0 || load_chip !== exp_load ||
                bus.ack1 !== exp_ack || grant !== ((k <= 3) ? 2'b10 : 2'b00)) begin
                miscompares++;
                $display("FAIL len0_c%0d: phi=%b phi_bar=%b id=%b load=%b ack1=%b grant=%b required 0/0/0/%b/%b",
                         k, phi, phi_bar, scan_id, load_chip, bus.ack1, grant, exp_load, exp_ack);
            end
            if (k == 3) bus.req1 = 1'b0;
        end
        tb_last = 1'b1;
    endtask

    task automatic test_clamp();
        bit ok;
        bus.data0 = {$urandom, $urandom, $urandom, $urandom};
        bus.len0  = 8'd200;
        bus.req0  = 1'b1;
        push_exp(1'b0, bus.data0, 200);
        wait_ack(1'b0, ok);
        vectors++;
        if (!ok || bit_cnt !== 8'd128) begin
            miscompares++;
            $display("FAIL clamp: ack=%0d bit_cnt=%0d required ack and 128", ok, bit_cnt);
        end
        bus.req0 = 1'b0;
        tb_last  = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        bus.data0 = {4{$urandom}};
        bus.len0  = 8'd10;
        bus.req0  = 1'b1;
        n = 0;
        while (bit_cnt !== 8'd5 || busy !== 1'b1) begin
            tick();
            n++;
            if (n == 3) begin bus.data1 = {4{$urandom}}; bus.len1 = 8'd3; bus.req1 = 1'b1; end
            if (n > BUDGET) break;
        end
        vectors++;
        if (n > BUDGET) begin miscompares++; $display("FAIL mid_reach: bit 5 not reached in %0d cycles", BUDGET); end
        reset = 1'b1;
        tick();
        vectors++;
        if ({grant, busy, bit_cnt, scan_id, phi, phi_bar, data_in, load_chip, bus.ack0, bus.ack1} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: grant=%b busy=%b bit_cnt=%0d pins=%b%b%b%b%b ack=%b%b required all 0",
                     grant, busy, bit_cnt, scan_id, phi, phi_bar, data_in, load_chip, bus.ack0, bus.ack1);
        end
        tick();
        reset   = 1'b0;
        tb_last = 1'b1;
        push_exp(1'b0, bus.data0, 10);
        push_exp(1'b1, bus.data1, 3);
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_rearb: grant=%b required 01", grant);
        end
        wait_ack(1'b0, ok); bus.req0 = 1'b0;
        wait_grant(2'b10, ok, n);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL mid_p1: no grant 10 within %0d cycles", BUDGET); end
        wait_ack(1'b1, ok); bus.req1 = 1'b0;
        tb_last = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int   mode, cnt;
        logic order [2];
        logic [SCAN_W-1:0] d [2];
        int unsigned l [2];
        bit ok;
        int n;
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            for (int p = 0; p < 2; p++) begin
                d[p] = {$urandom, $urandom, $urandom, $urandom};
                l[p] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            end
            bus.data0 = d[0]; bus.len0 = LEN_W'(l[0]);
            bus.data1 = d[1]; bus.len1 = LEN_W'(l[1]);
            if (mode == 0)      begin cnt = 1; order[0] = 1'b0; end
            else if (mode == 1) begin cnt = 1; order[0] = 1'b1; end
            else                begin cnt = 2; order[0] = ~tb_last; order[1] = tb_last; end
            for (int i = 0; i < cnt; i++) push_exp(order[i], d[order[i]], l[order[i]]);
            if (mode != 1) bus.req0 = 1'b1;
            if (mode != 0) bus.req1 = 1'b1;
            for (int i = 0; i < cnt; i++) begin
                wait_grant(order[i] ? 2'b10 : 2'b01, ok, n);
                vectors++;
                if (!ok) begin miscompares++; $display("FAIL rnd%0d_grant: port %0d not granted", it, order[i]); end
                if ($urandom_range(0, 1) == 1) begin
                    if (order[i]) begin bus.req1 = 1'b0; bus.data1 = {4{$urandom}}; bus.len1 = 8'd5; end
                    else          begin bus.req0 = 1'b0; bus.data0 = {4{$urandom}}; bus.len0 = 8'd5; end
                end
                wait_ack(order[i], ok);
                vectors++;
                if (!ok) begin miscompares++; $display("FAIL rnd%0d_ack: port %0d not acked", it, order[i]); end
                if (order[i]) bus.req1 = 1'b0;
                else          bus.req0 = 1'b0;
                tb_last = order[i];
            end
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0; bus.data0 = '0; bus.len0 = '0;
        bus.req1 = 1'b0; bus.data1 = '0; bus.len1 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie();
        test_len_zero();
        test_clamp();
        test_reset_mid();
        test_random();
        repeat (3) tick();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d expected transactions never acked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scan_chain_arbiter.md
Name: scan_chain_arbiter

Overview:
- Owns the tag chip's scan-chain GPIO pins (scan_id, phi, phi_bar, data_in, load_chip).
- Shares them between two requesters. Port 0 is the hop sequencer, which loads per-hop IF codes. Port 1 is the host/config path, which loads static chip configuration.
- Grants round-robin, serialises the granted word MSB-first with non-overlapping two-phase clocks, pulses load_chip, then acks the requester.
- Sits between the RX/hop control FSM and the GPIO mux, replacing a dedicated per-source scan driver.

Parameters:
- SCAN_W, 128, width of the scan data word.
- LEN_W, 8, width of the bit-length field; must hold SCAN_W.
- PHASE_CYCLES, 10, clk cycles per scan phase (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req0  in  1  hop-sequencer request, level, held until ack0
- data0  in  SCAN_W  port 0 scan word
- len0  in  LEN_W  port 0 number of bits to shift
- ack0  out  1  one-cycle completion pulse, port 0
- req1  in  1  host request, level, held until ack1
- data1  in  SCAN_W  port 1 scan word
- len1  in  LEN_W  port 1 number of bits to shift
- ack1  out  1  one-cycle completion pulse, port 1
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  transaction in progress
- bit_cnt  out  LEN_W  bits already shifted in current transaction
- scan_id  out  1  high throughout SHIFT
- scan_phi  out  1  phase-1 scan clock
- scan_phi_bar  out  1  phase-2 scan clock
- scan_data_in  out  1  serial data
- scan_load_chip  out  1  latch pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer favours port 0. Reset mid-transaction aborts immediately: no ack is issued and pins drop to 0 on the next cycle.
- States: IDLE, SHIFT, LOAD, ACK.
- IDLE (cycle C0): if any req is high, select the winner, latch its data and len, and clear bit_cnt.
  - Only one request: that port wins.
  - Both requests: the port not granted last wins.
  - len == 0: next state is LOAD.
  - len > SCAN_W: len is clamped to SCAN_W.
  - Otherwise: next state is SHIFT.
- grant and busy go high at C0+1 and stay high through ACK.
- SHIFT: each bit takes 4 phases of PHASE_CYCLES cycles each.
  - Phase 0: scan_data_in = current bit; phi = phi_bar = 0.
  - Phase 1: phi = 1.
  - Phase 2: phi = phi_bar = 0.
  - Phase 3: phi_bar = 1.
  - scan_data_in holds the bit through all 4 phases.
  - Bit order: data[len-1] first, down to data[0].
  - bit_cnt increments at the end of phase 3 of each bit.
  - phi and phi_bar are never high in the same cycle.
  - SHIFT occupies cycles C0+1 .. C0+len·4·P, where P = PHASE_CYCLES.
- LOAD: scan_id = 0, scan_load_chip = 1 for P cycles; scan_data_in = 0.
- ACK: one cycle; ack of the granted port = 1, pins idle. Ack cycle = C0 + len·4·P + P + 1.
- After ACK: return to IDLE with grant = 00 and busy = 0. The pointer updates to the port just served.
  - A request still high in that IDLE cycle is arbitrated normally, giving one idle cycle between back-to-back transactions.
- Handshake rules:
  - Data and len are sampled only at the grant, so later changes are ignored.
  - A requester dropping req before ack does not abort; the ack is still pulsed.
  - A requester must drop req within the cycle after ack, or it is treated as a new request.
- Counters: phase-cycle counter and phase index wrap internally. No output changes except at phase boundaries.

Test Plan:
- P=2, req0 only, data0=…0b101, len0=3 at C0 → grant=01 at C0+1; scan_data_in 1,0,1 during bits 0,1,2; load_chip high C0+25..C0+26; ack0 at C0+27; grant=00 and busy=0 at C0+28.
- P=2, req0 and req1 raised in the same cycle after reset → port 0 served first. req1 still held → grant=10 two cycles after ack0. Next simultaneous request → port 1 loses to port 0 only if port 1 was last served.
- P=2, len1=0 → no phi/phi_bar edges; load_chip high C0+1..C0+2; ack1 at C0+3.
- len0=200 with SCAN_W=128 → exactly 128 phi pulses and 128 phi_bar pulses; bit_cnt ends at 128.
- reset asserted mid-SHIFT (bit 5) → next cycle all outputs 0, no ack. After reset releases, a pending req1 is granted only after req0 wins any tie.
- Random long run with assertions:
  - phi & phi_bar is never 1.
  - grant is one-hot or zero.
  - Each ack coincides with the prior grant.
  - The serial stream reconstructs the latched data.
